// File: rtl/covox_sample_fifo_if.sv
// ---------------------------------------------------------------------------
// covox_sample_fifo_if
// Bus bundle between the Z80 I/O decode side and the Covox sample FIFO.
//
// Signals
//   iorq_n, wr_n  Z80 I/O request / write strobes, active low, synchronous to clk
//   addr          Z80 A[7:0]
//   din           Z80 data bus (sample byte)
//   clr_ovr       one-cycle pulse clearing the sticky overrun flag
//   sample_out    current playback level, unsigned 8-bit, to the mixer
//   fifo_empty    FIFO holds no entries
//   fifo_full     FIFO holds 2**DEPTH_LOG2 entries
//   overrun       sticky: a write was dropped because the FIFO was full
//   fifo_level    fill level wp-rp (only with COVOX_FIFO_LEVEL_EN defined)
//
// Modports
//   master  CPU / system side: drives the strobes, reads the status
//   slave   the FIFO block itself
// ---------------------------------------------------------------------------
interface covox_sample_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  iorq_n;
    logic                  wr_n;
    logic [7:0]            addr;
    logic [7:0]            din;
    logic                  clr_ovr;
    logic [7:0]            sample_out;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  overrun;
`ifdef COVOX_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0]   fifo_level;
`endif

    modport master (
        output iorq_n,
        output wr_n,
        output addr,
        output din,
        output clr_ovr,
        input  sample_out,
        input  fifo_empty,
        input  fifo_full,
`ifdef COVOX_FIFO_LEVEL_EN
        input  fifo_level,
`endif
        input  overrun
    );

    modport slave (
        input  iorq_n,
        input  wr_n,
        input  addr,
        input  din,
        input  clr_ovr,
        output sample_out,
        output fifo_empty,
        output fifo_full,
`ifdef COVOX_FIFO_LEVEL_EN
        output fifo_level,
`endif
        output overrun
    );
endinterface

// File: rtl/covox_sample_fifo.sv
// ---------------------------------------------------------------------------
// covox_sample_fifo
// Covox/Specdrum-style 8-bit sample port. CPU OUT writes to PORT_ADDR are
// queued in a small FIFO; one sample is played every DIV clocks so the
// output rate is fixed regardless of CPU write jitter. sample_out is an
// unsigned level (8'h80 = silence) feeding the mixer like the AY output.
//
// Parameters
//   PORT_ADDR   low I/O address byte decoded for sample writes
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2 entries (2..6)
//   DIV         clocks per playback sample (2..65535)
//
// Ports
//   clk    system clock (only clock)
//   rst_n  asynchronous reset, active low; discards all queued data at once
//   bus    covox_sample_fifo_if.slave (strobes, data, flags, sample_out)
//
// Optional feature
//   COVOX_FIFO_LEVEL_EN  when defined, bus.fifo_level = wp-rp is driven as a
//                        registered output updated with the pointers.
// ---------------------------------------------------------------------------
module covox_sample_fifo #(
    parameter logic [7:0] PORT_ADDR  = 8'hFB,
    parameter int         DEPTH_LOG2 = 4,
    parameter int         DIV        = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    covox_sample_fifo_if.slave bus
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam int                PTR_W    = DEPTH_LOG2 + 1;
    localparam int                DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [7:0]        SILENCE  = 8'h80;

    // -----------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------
    logic [7:0]        mem_q [DEPTH];

    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sel_q;
    logic [7:0]        sample_q, sample_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovr_q, ovr_d;

    // -----------------------------------------------------------------------
    // Decode and control strobes
    // -----------------------------------------------------------------------
    logic sel;
    logic push;
    logic tick;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic drop;

    assign sel  = ~bus.iorq_n & ~bus.wr_n & (bus.addr == PORT_ADDR);
    // Edge detect so a long-held strobe only pushes once per I/O cycle.
    assign push = sel & ~sel_q;
    assign tick = (div_q == DIV_LAST);

    // Status from the registered pointers (state before the edge).
    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[PTR_W-1] != rp_q[PTR_W-1]) &&
                   (wp_q[PTR_W-2:0] == rp_q[PTR_W-2:0]);

    always_comb begin
        do_pop   = 1'b0;
        do_push  = 1'b0;
        drop     = 1'b0;
        wp_d     = wp_q;
        rp_d     = rp_q;
        div_d    = div_q;
        sample_d = sample_q;
        ovr_d    = ovr_q;

        div_d = tick ? '0 : div_q + DIV_W'(1);

        // A pop on an empty FIFO is simply ignored (underrun holds the level).
        do_pop = tick & ~empty;
        // When full, a simultaneous pop frees the slot this push lands in.
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop;

        if (do_pop) begin
            rp_d     = rp_q + PTR_W'(1);
            sample_d = mem_q[rp_q[PTR_W-2:0]];
        end
        if (do_push) begin
            wp_d = wp_q + PTR_W'(1);
        end

        // Set beats clear when both happen in the same cycle.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end

        empty_d = (wp_d == rp_d);
        full_d  = (wp_d[PTR_W-1] != rp_d[PTR_W-1]) &&
                  (wp_d[PTR_W-2:0] == rp_d[PTR_W-2:0]);
    end

    // -----------------------------------------------------------------------
    // Sample memory: no reset so it maps onto RAM. When full with a push and
    // pop together, the write and read hit the same slot; the read returns
    // the old entry because sample_q samples it on the same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wp_q[PTR_W-2:0]] <= bus.din;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            div_q    <= '0;
            sel_q    <= 1'b0;
            sample_q <= SILENCE;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            div_q    <= div_d;
            sel_q    <= sel;
            sample_q <= sample_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef COVOX_FIFO_LEVEL_EN
    logic [PTR_W-1:0] level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= wp_d - rp_d;
        end
    end

    assign bus.fifo_level = level_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs: all straight from registers
    // -----------------------------------------------------------------------
    assign bus.sample_out = sample_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_covox_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_covox_sample_fifo
// Directed bench for covox_sample_fifo. Written samples are pushed into a
// scoreboard queue; at every playback tick the head is popped and becomes
// the expected sample_out. Flags are compared every cycle against the
// queue occupancy.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_covox_sample_fifo;

    localparam logic [7:0] PORT_ADDR  = 8'hFB;
    localparam int         DEPTH_LOG2 = 4;
    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam int         DIV        = 64;

    logic clk;
    logic rst_n;

    covox_sample_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    covox_sample_fifo #(
        .PORT_ADDR (PORT_ADDR),
        .DEPTH_LOG2(DEPTH_LOG2),
        .DIV       (DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / reference state
    logic [7:0] q [$];
    logic [7:0] exp_sample;
    logic       exp_ovr;
    int         div_m;
    bit         sel_prev;

    int checks_total;
    int checks_passed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_total++;
        assert (obs === exp_v) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    endtask

    task automatic model_reset();
        q.delete();
        exp_sample = 8'h80;
        exp_ovr    = 1'b0;
        div_m      = 0;
        sel_prev   = 1'b0;
    endtask

    task automatic drive(input logic iorq_n, input logic wr_n, input logic [7:0] addr,
                         input logic [7:0] din, input logic clr);
        bus.iorq_n  = iorq_n;
        bus.wr_n    = wr_n;
        bus.addr    = addr;
        bus.din     = din;
        bus.clr_ovr = clr;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    endtask

    // One clock: inputs are already set; model updates on the edge, DUT
    // outputs are compared on the following falling edge.
    task automatic cycle();
        bit sel, tick, pushed, drop;
        @(posedge clk);
        sel    = !bus.iorq_n && !bus.wr_n && (bus.addr == PORT_ADDR);
        tick   = (div_m == DIV - 1);
        div_m  = tick ? 0 : div_m + 1;
        pushed = sel && !sel_prev;
        sel_prev = sel;
        drop   = 1'b0;
        if (tick && q.size() != 0) begin
            exp_sample = q.pop_front();
            $display("t=%0t pop  sample=%02h", $time, exp_sample);
        end
        if (pushed) begin
            if (q.size() < DEPTH) q.push_back(bus.din);
            else drop = 1'b1;
            $display("t=%0t push din=%02h %s", $time, bus.din, drop ? "dropped" : "queued");
        end
        if (drop) exp_ovr = 1'b1;
        else if (bus.clr_ovr) exp_ovr = 1'b0;
        @(negedge clk);
        check("sample_out", 32'(bus.sample_out), 32'(exp_sample));
        check("fifo_empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
        check("fifo_full",  32'(bus.fifo_full),  32'(q.size() == DEPTH));
        check("overrun",    32'(bus.overrun),    32'(exp_ovr));
`ifdef COVOX_FIFO_LEVEL_EN
        check("fifo_level", 32'(bus.fifo_level), 32'(q.size()));
`endif
    endtask

    task automatic out_port(input logic [7:0] addr, input logic [7:0] d);
        drive(1'b0, 1'b0, addr, d, 1'b0);
        cycle();
        idle();
        cycle();
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (q.size() != 0 && b < budget) begin
            cycle();
            b++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        idle();
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_sample", 32'(bus.sample_out), 32'h80);
        check("rst_empty",  32'(bus.fifo_empty), 32'd1);
        check("rst_full",   32'(bus.fifo_full),  32'd0);
        check("rst_ovr",    32'(bus.overrun),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle playback stays at midscale
        repeat (3 * DIV) cycle();

        // 2: two samples plus a write to another port that must be ignored
        out_port(PORT_ADDR, 8'h12);
        out_port(8'hFA, 8'h77);
        out_port(PORT_ADDR, 8'h34);
        drain(4 * DIV);
        repeat (DIV + 2) cycle();
        check("t2_held", 32'(bus.sample_out), 32'h34);
        check("t2_empty", 32'(bus.fifo_empty), 32'd1);

        // 3: long strobe pushes once
        while (div_m != 0) cycle();
        drive(1'b0, 1'b0, PORT_ADDR, 8'h55, 1'b0);
        repeat (10) cycle();
        idle();
        cycle();
        check("t3_one_entry", 32'(bus.fifo_empty), 32'd0);
`ifdef COVOX_FIFO_LEVEL_EN
        check("t3_level", 32'(bus.fifo_level), 32'd1);
`endif
        drain(4 * DIV);

        // 4: 17 writes between ticks -> full, then drop with overrun
        while (div_m != 0) cycle();
        for (int i = 0; i < 17; i++) begin
            out_port(PORT_ADDR, 8'hA0 + 8'(i));
            if (i == 15) check("t4_full16", 32'(bus.fifo_full), 32'd1);
        end
        check("t4_ovr", 32'(bus.overrun), 32'd1);
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
        cycle();
        idle();
        check("t4_clr", 32'(bus.overrun), 32'd0);

        // 5: write landing on the tick while full
        while (div_m != DIV - 1) cycle();
        drive(1'b0, 1'b0, PORT_ADDR, 8'hC5, 1'b0);
        cycle();
        idle();
        check("t5_full", 32'(bus.fifo_full), 32'd1);
        check("t5_ovr",  32'(bus.overrun),   32'd0);
        check("t5_pop",  32'(bus.sample_out), 32'hA0);
        cycle();
        drain(20 * DIV);
        repeat (DIV) cycle();
        check("t5_last", 32'(bus.sample_out), 32'hC5);

        // 6: async reset with 5 entries queued
        for (int i = 0; i < 5; i++) out_port(PORT_ADDR, 8'h60 + 8'(i));
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_sample", 32'(bus.sample_out), 32'h80);
        check("t6_rst_empty",  32'(bus.fifo_empty), 32'd1);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_port(PORT_ADDR, 8'hE6);
        repeat (DIV) cycle();
        check("t6_first", 32'(bus.sample_out), 32'hE6);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
